q1_sweep_checker: RTL

- Self-timed stimulus and response stage for the 4-input combinational function block (inputs a, b, c, d; output f).
- Sits on both sides of that block. It drives all 16 input combinations in ascending order with a programmable hold time. It samples f at the end of each hold and compares it against a parameterised expected truth table.
- Reports pass/fail, a mismatch count and the first failing vector index through a start/done handshake.

---
 rtl/q1_sweep_checker.sv | 107 ++++++++++
 1 files changed

// File: rtl/q1_sweep_checker.sv
// q1_sweep_checker: exhaustive stimulus/response checker for a 4-input
// combinational block. Walks {a,b,c,d} through 0..15 and holds each vector
// for HOLD_CYCLES clocks. Samples f on the last cycle of each hold and
// compares it against EXPECTED. Reports the results through a start/done
// handshake.
module q1_sweep_checker #(
  parameter logic [15:0] EXPECTED    = 16'h0000,
  parameter int          HOLD_CYCLES = 20,
  parameter int          HOLD_W      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  input  logic       f,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_err_idx,
  output logic       err_valid
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_t            state;
  logic [3:0]        idx;
  logic [HOLD_W-1:0] hold_cnt;

  logic       hold_end;
  logic       mismatch;
  logic [4:0] err_next;

  // End-of-hold detect and the result of comparing the current vector.
  // err_next folds the final vector into pass on the same edge.
  assign hold_end = (hold_cnt == HOLD_LAST);
  assign mismatch = (f != EXPECTED[idx]);
  assign err_next = err_count + 5'(mismatch);

  // Sweep sequencer. All outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      hold_cnt      <= '0;
      {a, b, c, d}  <= 4'b0000;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      err_valid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state         <= RUN;
            idx           <= '0;
            hold_cnt      <= '0;
            {a, b, c, d}  <= 4'b0000;
            busy          <= 1'b1;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            err_valid     <= 1'b0;
          end
        end
        RUN: begin
          if (hold_end) begin
            err_count <= err_next;
            if (mismatch && !err_valid) begin
              first_err_idx <= idx;
              err_valid     <= 1'b1;
            end
            hold_cnt <= '0;
            if (idx != 4'hF) begin
              idx          <= idx + 4'd1;
              {a, b, c, d} <= idx + 4'd1;
            end else begin
              // Last vector judged: present the verdict for one cycle.
              state        <= FINISH;
              idx          <= '0;
              {a, b, c, d} <= 4'b0000;
              busy         <= 1'b0;
              done         <= 1'b1;
              pass         <= (err_next == 5'd0);
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
